// File: rtl/peripheral_msi_pkg.sv
// peripheral_msi_pkg: shared AHB-Lite encodings, slave FSM states and lane helpers
package peripheral_msi_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2, HSIZE_DWORD = 3'd3;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] a);
    return size == HSIZE_HALF ? a[0] : size == HSIZE_WORD ? |a[1:0] : size == HSIZE_DWORD ? |a : 1'b0;
  endfunction
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] base;
    base = size == HSIZE_BYTE ? 8'h01 : size == HSIZE_HALF ? 8'h03 : size == HSIZE_WORD ? 8'h0F : 8'hFF;
    return base << off;
  endfunction
endpackage

// File: rtl/peripheral_msi_ram_1rw.sv
// peripheral_msi_ram_1rw: single-port RAM, byte-enable write, asynchronous read
module peripheral_msi_ram_1rw #(
  parameter int DW = 64,
  parameter int WORDS = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DW/8-1:0]          be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++)
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/peripheral_msi_ahb_sram_slave.sv
// peripheral_msi_ahb_sram_slave: AHB-Lite SRAM slave with configurable data-phase wait states
module peripheral_msi_ahb_sram_slave
  import peripheral_msi_pkg::*;
#(
  parameter int PLEN = 64,
  parameter int XLEN = 64,
  parameter int MEM_BYTES = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic [XLEN-1:0] HRDATA,
  output logic            HREADYOUT,
  output logic            HRESP
);
  localparam int NB = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int IW = AW > OFF ? AW - OFF : 1;
  state_t          state;
  logic [3:0]      cnt;
  logic            pend, wr, accept, err, done, resp_q, ready_q;
  logic [2:0]      size;
  logic [OFF-1:0]  off;
  logic [IW-1:0]   idx;
  logic [7:0]      mask;
  logic [XLEN-1:0] rdata;
  logic            ctl_unused;
  assign ctl_unused = ^{HBURST, HPROT, HMASTLOCK};
  assign accept = HSEL && HREADY && ready_q && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign err = (HADDR >= PLEN'(MEM_BYTES)) || (HSIZE > 3'(OFF)) || misaligned(HSIZE, HADDR[2:0]);
  // pend marks a live non-error data phase; it completes once the FSM is back in IDLE
  assign done = state == ST_IDLE && pend;
  assign mask = lane_mask(size, 3'(off));
  assign HRDATA = done && !wr ? rdata : '0;
  assign HREADYOUT = ready_q;
  assign HRESP = resp_q;
  peripheral_msi_ram_1rw #(.DW(XLEN), .WORDS(MEM_BYTES / NB)) u_ram (
    .clk(HCLK), .we(done && wr), .be(mask[NB-1:0]), .addr(idx), .wdata(HWDATA), .rdata(rdata)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt <= '0;
      pend <= 1'b0;
      wr <= 1'b0;
      size <= '0;
      off <= '0;
      idx <= '0;
      ready_q <= 1'b1;
      resp_q <= HRESP_OKAY;
    end else if (accept) begin
      pend <= !err;
      wr <= HWRITE;
      size <= HSIZE;
      off <= HADDR[OFF-1:0];
      idx <= HADDR[OFF +: IW];
      state <= err ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
      cnt <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      ready_q <= !err && WAIT_STATES == 0;
      resp_q <= err ? HRESP_ERROR : HRESP_OKAY;
    end else if (state == ST_WAIT) begin
      state <= cnt == 0 ? ST_IDLE : ST_WAIT;
      ready_q <= cnt == 0;
      cnt <= cnt == 0 ? cnt : cnt - 4'd1;
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
      ready_q <= 1'b1;
    end else begin
      state <= ST_IDLE;
      pend <= 1'b0;
      ready_q <= 1'b1;
      resp_q <= HRESP_OKAY;
    end
endmodule

// File: tb/tb_peripheral_msi_ahb_sram_slave.sv
// tb_peripheral_msi_ahb_sram_slave: table-driven bench on a zero-wait slave plus wait-state/reset sequences
module tb_peripheral_msi_ahb_sram_slave;
  import peripheral_msi_pkg::*;
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic        rdy;
    logic        rsp;
    logic [63:0] rd;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst0_n, rst3_n, sel0, sel3, write, ready0, ready3, resp0, resp3;
  logic [1:0]  trans;
  logic [2:0]  size;
  logic [63:0] addr, wdata, rdata0, rdata3;
  logic [2:0]  burst = 3'd0;
  logic [3:0]  prot = 4'd0;
  logic        lock = 1'b0;
  int checks = 0, fails = 0;
  vec_t v[$];
  peripheral_msi_ahb_sram_slave #(.PLEN(64), .XLEN(64), .MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst0_n), .HSEL(sel0), .HADDR(addr), .HWDATA(wdata), .HWRITE(write),
    .HSIZE(size), .HBURST(burst), .HPROT(prot), .HTRANS(trans), .HMASTLOCK(lock), .HREADY(ready0),
    .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );
  peripheral_msi_ahb_sram_slave #(.PLEN(64), .XLEN(64), .MEM_BYTES(4096), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst3_n), .HSEL(sel3), .HADDR(addr), .HWDATA(wdata), .HWRITE(write),
    .HSIZE(size), .HBURST(burst), .HPROT(prot), .HTRANS(trans), .HMASTLOCK(lock), .HREADY(ready3),
    .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic s, input logic [1:0] t, input logic w, input logic [63:0] a,
                     input logic [2:0] sz, input logic [63:0] wd, input logic rdy, input logic rsp,
                     input logic [63:0] rd);
    vec_t x;
    x.sel = s; x.trans = t; x.wr = w; x.addr = a; x.size = sz; x.wdata = wd;
    x.rdy = rdy; x.rsp = rsp; x.rd = rd;
    v.push_back(x);
  endtask
  task automatic drive3(input logic s, input logic [1:0] t, input logic w, input logic [63:0] a,
                        input logic [2:0] sz, input logic [63:0] wd);
    @(posedge clk);
    #1;
    sel0 = 1'b0; sel3 = s; trans = t; write = w; addr = a; size = sz; wdata = wd;
  endtask
  task automatic count_wait(output int n, output logic [63:0] rd_low);
    n = 0;
    rd_low = '0;
    @(negedge clk);
    while (!ready3 && n < 20) begin
      n++;
      rd_low |= rdata3;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    logic [63:0] rl;
    rst0_n = 1'b0; rst3_n = 1'b0;
    sel0 = 1'b0; sel3 = 1'b0; trans = HTRANS_IDLE; write = 1'b0; addr = '0; size = '0; wdata = '0;
    add(1, HTRANS_NONSEQ, 1, 64'h10, 3, 64'h0, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 0, 64'h10, 3, 64'h1122334455667788, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 0, 64'h1122334455667788);
    add(1, HTRANS_NONSEQ, 1, 64'h10, 3, 64'h0, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 1, 64'h13, 0, 64'h0, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 0, 64'h10, 3, 64'hFFFFFFFFABFFFFFF, 1, 0, 64'h0);
    add(1, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 0, 64'h00000000AB000000);
    add(1, HTRANS_NONSEQ, 1, 64'h16, 1, 64'h0, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 1, 64'h14, 2, 64'hBEEF111122223333, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 0, 64'h10, 3, 64'h123456789ABCDEF0, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 0, 64'h12345678AB000000);
    add(1, HTRANS_NONSEQ, 0, 64'h1000, 3, 64'h0, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 0, 1, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 1, 64'h0);
    add(1, HTRANS_NONSEQ, 1, 64'h11, 1, 64'h0, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1, 64'h0);
    add(1, HTRANS_NONSEQ, 1, 64'h1010, 3, 64'h0, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1, 64'h0);
    add(1, HTRANS_NONSEQ, 1, 64'h0, 4, 64'h0, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0);
    add(1, HTRANS_NONSEQ, 0, 64'h10, 3, 64'hFFFFFFFFFFFFFFFF, 1, 1, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 0, 64'h12345678AB000000);
    add(1, HTRANS_NONSEQ, 1, 64'h20, 3, 64'h0, 1, 0, 64'h0);
    add(1, HTRANS_SEQ, 0, 64'h20, 3, 64'hDEAD, 1, 0, 64'h0);
    add(1, HTRANS_BUSY, 1, 64'h20, 3, 64'h0, 1, 0, 64'hDEAD);
    add(0, HTRANS_NONSEQ, 1, 64'h20, 3, 64'h1111, 1, 0, 64'h0);
    add(1, HTRANS_NONSEQ, 0, 64'h20, 3, 64'h2222, 1, 0, 64'h0);
    add(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0, 1, 0, 64'hDEAD);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready0), 64'h1);
    chk("reset_resp", 64'(resp0), 64'h0);
    chk("reset_rdata", rdata0, 64'h0);
    chk("reset3_ready", 64'(ready3), 64'h1);
    rst0_n = 1'b1; rst3_n = 1'b1;
    foreach (v[k]) begin
      @(posedge clk);
      #1;
      sel0 = v[k].sel; sel3 = 1'b0; trans = v[k].trans; write = v[k].wr;
      addr = v[k].addr; size = v[k].size; wdata = v[k].wdata;
      @(negedge clk);
      chk($sformatf("row%0d_ready", k), 64'(ready0), 64'(v[k].rdy));
      chk($sformatf("row%0d_resp", k), 64'(resp0), 64'(v[k].rsp));
      chk($sformatf("row%0d_rdata", k), rdata0, v[k].rd);
    end
    drive3(1, HTRANS_NONSEQ, 1, 64'h40, 3, 64'h0);
    drive3(0, HTRANS_IDLE, 0, 64'h0, 0, 64'hCAFE);
    count_wait(n, rl);
    chk("ws3_write_waits", 64'(n), 64'd3);
    chk("ws3_write_resp", 64'(resp3), 64'h0);
    drive3(1, HTRANS_NONSEQ, 0, 64'h40, 3, 64'h0);
    drive3(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0);
    count_wait(n, rl);
    chk("ws3_read_waits", 64'(n), 64'd3);
    chk("ws3_read_rdata", rdata3, 64'hCAFE);
    chk("ws3_read_resp", 64'(resp3), 64'h0);
    chk("ws3_wait_rdata_zero", rl, 64'h0);
    drive3(1, HTRANS_NONSEQ, 1, 64'h40, 3, 64'h0);
    drive3(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h5555);
    @(negedge clk);
    chk("ws3_wait1_ready", 64'(ready3), 64'h0);
    @(posedge clk);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready3), 64'h1);
    chk("rst_mid_resp", 64'(resp3), 64'h0);
    chk("rst_mid_rdata", rdata3, 64'h0);
    @(negedge clk);
    rst3_n = 1'b1;
    drive3(1, HTRANS_NONSEQ, 0, 64'h40, 3, 64'h0);
    drive3(0, HTRANS_IDLE, 0, 64'h0, 0, 64'h0);
    count_wait(n, rl);
    chk("rst_read_waits", 64'(n), 64'd3);
    chk("rst_word_unchanged", rdata3, 64'hCAFE);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
